// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA fetch > queued game write > game readback.
// Optional readback path compiled only when VRAM_ARB_READBACK_EN is defined.
module vram_arbiter #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              vga_re,
  input  logic [9:0]                        vga_raddr,
  output logic [DATA_W-1:0]                 vga_rdata,
  input  logic                              gm_we,
  input  logic [9:0]                        gm_waddr,
  input  logic [DATA_W-1:0]                 gm_wdata,
  output logic                              gm_wready,
  input  logic                              gm_re,
  input  logic [9:0]                        gm_raddr,
  output logic                              gm_rready,
  output logic                              gm_rvalid,
  output logic [DATA_W-1:0]                 gm_rdata,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [9:0]                        mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]       wq_count,
  output logic                              err_ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {G_NONE, G_VGA, G_WR, G_GRD} grant_t;

  grant_t            state;
  grant_t            grant;

  logic [9:0]        q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              err;
  logic              q_empty;
  logic              wready_i;
  logic              rready_i;
  logic              rd_req;
  logic              push;
  logic              pop;
  logic [9:0]        addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] vga_hold;

  assign q_empty   = (count == '0);
  assign wready_i  = (count < CW'(FIFO_DEPTH));
  assign gm_wready = wready_i;
  assign push      = ~reset & gm_we & wready_i;
  assign pop       = (grant == G_WR);

`ifdef VRAM_ARB_READBACK_EN
  logic [DATA_W-1:0] rd_hold;

  // Reads wait for an empty queue so they can never overtake a pending write.
  assign rready_i  = ~reset & ~vga_re & q_empty & ~gm_we;
  assign rd_req    = gm_re & rready_i;
  assign gm_rready = rready_i;
  assign gm_rvalid = ~reset & (state == G_GRD);
  assign gm_rdata  = reset ? '0 : ((state == G_GRD) ? mem_rdata : rd_hold);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_hold <= '0;
    end else if (state == G_GRD) begin
      rd_hold <= mem_rdata;
    end
  end
`else
  logic unused_readback;

  assign unused_readback = ^{gm_re, gm_raddr};
  assign rready_i  = 1'b0;
  assign rd_req    = 1'b0;
  assign gm_rready = 1'b0;
  assign gm_rvalid = 1'b0;
  assign gm_rdata  = '0;
`endif

  always_comb begin
    grant = G_NONE;
    if (!reset) begin
      if (vga_re)        grant = G_VGA;
      else if (!q_empty) grant = G_WR;
      else if (rd_req)   grant = G_GRD;
    end
  end

  // Address/data buses hold their last driven value on idle cycles.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    unique case (grant)
      G_VGA: begin
        mem_en   = 1'b1;
        mem_addr = vga_raddr;
      end
      G_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = q_addr[rd_ptr];
        mem_wdata = q_data[rd_ptr];
      end
`ifdef VRAM_ARB_READBACK_EN
      G_GRD: begin
        mem_en   = 1'b1;
        mem_addr = gm_raddr;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= gm_waddr;
      q_data[wr_ptr] <= gm_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= G_NONE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err      <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      vga_hold <= '0;
    end else begin
      state   <= grant;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (gm_we && !wready_i) err <= 1'b1;
      if (state == G_VGA) vga_hold <= mem_rdata;
    end
  end

  assign vga_rdata = reset ? '0 : ((state == G_VGA) ? mem_rdata : vga_hold);
  assign wq_count  = reset ? '0 : count;
  assign err_ovf   = ~reset & err;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 4, cell-code width stored per 20x20 grid block.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, game write-queue entries (power of 2, >=2).
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port vga_re  in  1  VGA block-fetch strobe, single-cycle pulse.
REQ-006 SHALL have port vga_raddr  in  10  VGA cell address {hblock[4:0], vblock[4:0]}.
REQ-007 SHALL have port vga_rdata  out  DATA_W  VGA fetched cell code.
REQ-008 SHALL have port gm_we  in  1  game-logic write request.
REQ-009 SHALL have ports gm_waddr  in  10 and gm_wdata  in  DATA_W  game write address/data.
REQ-010 SHALL have port gm_wready  out  1  write queue can accept.
REQ-011 SHALL have ports gm_re  in  1 and gm_raddr  in  10  game readback request/address.
REQ-012 SHALL have ports gm_rready  out  1, gm_rvalid  out  1, gm_rdata  out  DATA_W  readback handshake/data.
REQ-013 SHALL have ports mem_en  out  1, mem_we  out  1, mem_addr  out  10, mem_wdata  out  DATA_W, mem_rdata  in  DATA_W  single-port RAM, rdata valid 1 cycle after read.
REQ-014 SHALL have ports wq_count  out  clog2(FIFO_DEPTH)+1 and err_ovf  out  1  queue occupancy, sticky overflow.

Function
REQ-015 SHALL issue at most one RAM access per cycle; fixed priority: VGA read > queued write > game read.
REQ-016 SHALL, on vga_re=1, drive mem_en=1, mem_we=0, mem_addr=vga_raddr same cycle (combinational, never stalled).
REQ-017 SHALL present vga_rdata=mem_rdata in cycle N+1 after VGA grant at N, then hold that value until the next VGA grant's N+1.
REQ-018 SHALL accept a write when gm_we & gm_wready; gm_wready = (wq_count < FIFO_DEPTH), from registered count only.
REQ-019 SHALL drop a write with gm_we=1, gm_wready=0, and set err_ovf=1 until reset.
REQ-020 SHALL pop the queue head to RAM (mem_we=1) in any cycle with queue non-empty and vga_re=0; no same-cycle push-to-RAM bypass (minimum write latency 1 cycle after accept).
REQ-021 SHALL handle simultaneous push and pop: count unchanged, FIFO order preserved.
REQ-022 SHALL drive gm_rready = ~vga_re & (wq_count==0) & ~gm_we; reads never pass queued writes.
REQ-023 SHALL, on gm_re & gm_rready at cycle N, issue RAM read at N, pulse gm_rvalid=1 at N+1 with gm_rdata=mem_rdata; gm_rdata holds until the next readback.
REQ-024 SHALL track last grant in a registered state {G_NONE, G_VGA, G_WR, G_GRD}, updated each cycle from the current grant; it steers mem_rdata capture.
REQ-025 SHALL drive mem_en=0, mem_we=0 and hold mem_addr/mem_wdata when no request is granted.
REQ-026 SHALL wrap FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-027 SHALL, while reset=1: empty queue, wq_count=0, err_ovf=0, state=G_NONE, vga_rdata=0, gm_rdata=0, gm_rvalid=0, mem_en=0, mem_we=0.
REQ-028 SHALL discard queued writes and suppress gm_rvalid for any read granted the cycle reset asserts.
REQ-029 SHALL ignore all requests during reset; first grant possible the cycle after deassertion.

Configuration
REQ-030 SHALL compile the game readback path only when VRAM_ARB_READBACK_EN is defined.
REQ-031 SHALL, without VRAM_ARB_READBACK_EN, tie gm_rready=0, gm_rvalid=0, gm_rdata=0, never grant G_GRD; VGA and write behaviour unchanged.

Verification
REQ-032 SHALL verify: vga_re=1, vga_raddr=10'h0A5, RAM[0A5]=3 -> mem_addr=0A5 same cycle, vga_rdata=3 next cycle, held until the next VGA fetch.
REQ-033 SHALL verify: 4 writes (addr 1..4, data 1..4) on consecutive cycles, vga_re every other cycle -> RAM written in order 1..4, no write on vga_re cycles, wq_count returns to 0.
REQ-034 SHALL verify: 5 back-to-back writes with vga_re held 1 -> 5th dropped, gm_wready=0 at count 4, err_ovf=1 sticky.
REQ-035 SHALL verify (macro on): write addr 7 data 2 then gm_re addr 7 -> gm_rready=0 until queue empty, gm_rvalid one cycle after grant with gm_rdata=2.
REQ-036 SHALL verify: reset with 3 queued writes and read in flight -> no further mem_we, gm_rvalid=0, wq_count=0, err_ovf=0.
REQ-037 SHALL verify (macro off): gm_re=1 held 10 cycles -> gm_rready=0, gm_rvalid=0, no G_GRD grant.
